// File: rtl/spi_gyro_responder.sv
// SPI mode-3 target emulating a 3-axis gyro register interface.
// All SPI pins are oversampled by clk. Nothing is clocked by sclk.
// Reads use a 48-bit sample snapshot taken at the cs falling edge.
module spi_gyro_responder #(
    parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
    parameter logic [7:0] CTRL1_RST    = 8'h07
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic [39:0] ctrl_regs,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic        cs_prev_q, sclk_prev_q;
    logic [1:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        rw_q, rw_d;
    logic        ms_q, ms_d;
    logic [5:0]  addr_q, addr_d;
    logic        miso_q, miso_d;
    logic [39:0] ctrl_q, ctrl_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [47:0] snap_q, snap_d;

    logic        cs_s, sclk_s, mosi_s;
    logic        cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [7:0]  cmd_shift, rx_shift;
    logic [5:0]  addr_nxt;

    // Register read map, evaluated against the transaction snapshot.
    function automatic logic [7:0] rd_val(input logic [5:0] a,
                                          input logic [47:0] snap,
                                          input logic [39:0] ctrl);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            6'h0F:                                v = WHO_AM_I_VAL;
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24:    v = ctrl[{a[2:0], 3'b000} +: 8];
            6'h28:                                v = snap[7:0];
            6'h29:                                v = snap[15:8];
            6'h2A:                                v = snap[23:16];
            6'h2B:                                v = snap[31:24];
            6'h2C:                                v = snap[39:32];
            6'h2D:                                v = snap[47:40];
            default:                              v = 8'h00;
        endcase
        return v;
    endfunction

    assign cs_s      = cs_sync_q[1];
    assign sclk_s    = sclk_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign cmd_shift = {cmd_q[6:0], mosi_s};
    assign rx_shift  = {rx_q[6:0], mosi_s};
    assign addr_nxt  = ms_q ? addr_q + 6'd1 : addr_q;

    // Synchronisers and edge history. cs resets low so that a cs held low
    // across reset never looks like a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= 2'b00;
            sclk_sync_q <= 2'b11;
            mosi_sync_q <= 2'b00;
            cs_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b1;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], cs};
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    // Transaction FSM: command byte, then repeating data bytes.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        ms_d        = ms_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        ctrl_d      = ctrl_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        snap_d      = snap_q;
        if (cs_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = 3'd0;
            snap_d    = {sample_z, sample_y, sample_x};
        end else if (cs_rise) begin
            state_d = S_IDLE;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                S_CMD: begin
                    if (sclk_rise) begin
                        cmd_d     = cmd_shift;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d      = cmd_shift[7];
                            ms_d      = cmd_shift[6];
                            addr_d    = cmd_shift[5:0];
                            if (cmd_shift[7])
                                tx_d = rd_val(cmd_shift[5:0], snap_q, ctrl_q);
                            state_d   = S_DATA;
                            bit_cnt_d = 3'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (rw_q) begin
                        if (sclk_fall) begin
                            miso_d = tx_q[7];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                addr_d    = addr_nxt;
                                tx_d      = rd_val(addr_nxt, snap_q, ctrl_q);
                                bit_cnt_d = 3'd0;
                            end
                        end
                    end else if (sclk_rise) begin
                        rx_d      = rx_shift;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (addr_q >= 6'h20 && addr_q <= 6'h24) begin
                                ctrl_d[{addr_q[2:0], 3'b000} +: 8] = rx_shift;
                                wr_addr_d   = addr_q;
                                wr_data_d   = rx_shift;
                                wr_strobe_d = 1'b1;
                            end
                            addr_d    = addr_nxt;
                            bit_cnt_d = 3'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            cmd_q       <= 8'h00;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            rw_q        <= 1'b0;
            ms_q        <= 1'b0;
            addr_q      <= 6'd0;
            miso_q      <= 1'b0;
            ctrl_q      <= {32'h0, CTRL1_RST};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 6'd0;
            wr_data_q   <= 8'h00;
            snap_q      <= 48'h0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            ms_q        <= ms_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            ctrl_q      <= ctrl_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            snap_q      <= snap_d;
        end
    end

    assign miso      = miso_q;
    assign ctrl_regs = ctrl_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_gyro_responder.sv
// Bench for spi_gyro_responder: an SPI master drives transactions and pushes
// expected read bytes / register writes into queues; independent monitors
// decode miso and wr_strobe and compare against those queues.
module tb_spi_gyro_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, sclk, mosi;
    logic        miso;
    logic [15:0] sample_x, sample_y, sample_z;
    logic [39:0] ctrl_regs;
    logic        wr_strobe;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    int total = 0;
    int bad   = 0;
    int nstrobe = 0;
    logic rd_cap = 1'b0;

    logic [7:0]  exp_rd[$];
    logic [13:0] exp_wr[$];

    spi_gyro_responder dut (
        .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
        .ctrl_regs(ctrl_regs), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic half();
        repeat (6) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sclk = 1'b0;
            mosi = b[i];
            half();
            sclk = 1'b1;
            half();
        end
    endtask

    task automatic xfer(input logic [7:0] b);
        xfer_bits(b, 8);
    endtask

    task automatic cs_lo();
        cs = 1'b0;
        half(); half();
    endtask

    task automatic cs_hi();
        half();
        cs = 1'b1;
        half(); half();
    endtask

    // Read monitor: reassemble miso bytes on sclk rises during read data phases.
    initial begin
        logic [7:0] sh;
        int nb;
        sh = 8'h00;
        nb = 0;
        forever begin
            @(posedge sclk or posedge cs);
            if (cs) nb = 0;
            else if (rd_cap) begin
                sh = {sh[6:0], miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_rd.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rd_unexpected: got %h expected none", sh);
                    end else begin
                        chk("rd_byte", 64'(sh), 64'(exp_rd.pop_front()));
                    end
                end
            end
        end
    end

    // Write monitor: every cycle wr_strobe is high must match one expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_strobe) begin
                nstrobe++;
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected: got addr %h data %h expected none", wr_addr, wr_data);
                end else begin
                    chk("wr_addr_data", 64'({wr_addr, wr_data}), 64'(exp_wr.pop_front()));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; cs = 1'b1; sclk = 1'b1; mosi = 1'b0;
        sample_x = 16'h1234; sample_y = 16'hABCD; sample_z = 16'h8001;
        repeat (5) @(negedge clk);
        chk("rst_miso", 64'(miso), 64'd0);
        chk("rst_strobe", 64'(wr_strobe), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_ctrl", 64'(ctrl_regs), 64'h00_0000_0007);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // single write to CTRL_REG1
        exp_wr.push_back({6'h20, 8'h0F});
        cs_lo(); xfer(8'h20); xfer(8'h0F); cs_hi();
        chk("ctrl1_after_write", 64'(ctrl_regs), 64'h00_0000_000F);

        // WHO_AM_I read
        exp_rd.push_back(8'hD3);
        cs_lo(); xfer(8'h8F); rd_cap = 1'b1; xfer(8'h00); rd_cap = 1'b0; cs_hi();

        // burst read of all axes; samples change mid-transaction
        exp_rd.push_back(8'h34); exp_rd.push_back(8'h12);
        exp_rd.push_back(8'hCD); exp_rd.push_back(8'hAB);
        exp_rd.push_back(8'h01); exp_rd.push_back(8'h80);
        cs_lo(); xfer(8'hE8); rd_cap = 1'b1;
        xfer(8'h00); xfer(8'h00);
        sample_x = 16'h0; sample_y = 16'h0; sample_z = 16'h0;
        repeat (4) xfer(8'h00);
        rd_cap = 1'b0; cs_hi();
        sample_x = 16'h1234; sample_y = 16'hABCD; sample_z = 16'h8001;

        // non-increment read repeats the same register
        exp_rd.push_back(8'h34); exp_rd.push_back(8'h34);
        cs_lo(); xfer(8'hA8); rd_cap = 1'b1; xfer(8'h00); xfer(8'h00); rd_cap = 1'b0; cs_hi();

        // burst write across CTRL1..5, sixth byte lands on 0x25 and is dropped
        exp_wr.push_back({6'h20, 8'h0F}); exp_wr.push_back({6'h21, 8'h00});
        exp_wr.push_back({6'h22, 8'h00}); exp_wr.push_back({6'h23, 8'h10});
        exp_wr.push_back({6'h24, 8'h55});
        cs_lo(); xfer(8'h60);
        xfer(8'h0F); xfer(8'h00); xfer(8'h00); xfer(8'h10); xfer(8'h55); xfer(8'h99);
        cs_hi();
        chk("ctrl_after_burst", 64'(ctrl_regs), 64'h55_1000_000F);
        chk("strobes_after_burst", 64'(nstrobe), 64'd6);

        // partial write byte aborted by cs high
        cs_lo(); xfer(8'h23); xfer_bits(8'hFF, 4); cs_hi();
        chk("ctrl_after_partial", 64'(ctrl_regs), 64'h55_1000_000F);
        chk("strobes_after_partial", 64'(nstrobe), 64'd6);

        // reset in the middle of a burst read
        exp_rd.push_back(8'h34);
        cs_lo(); xfer(8'hE8); rd_cap = 1'b1; xfer(8'h00); rd_cap = 1'b0;
        xfer_bits(8'h00, 3);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_miso", 64'(miso), 64'd0);
        chk("midrst_strobe", 64'(wr_strobe), 64'd0);
        chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
        chk("midrst_wr_data", 64'(wr_data), 64'd0);
        chk("midrst_ctrl", 64'(ctrl_regs), 64'h00_0000_0007);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // cs still low: clocks must be ignored until a fresh cs fall
        xfer(8'h8F); xfer(8'hFF);
        chk("postrst_idle_miso", 64'(miso), 64'd0);
        cs_hi();

        exp_rd.push_back(8'hD3);
        cs_lo(); xfer(8'h8F); rd_cap = 1'b1; xfer(8'h00); rd_cap = 1'b0; cs_hi();

        repeat (10) @(negedge clk);
        chk("final_strobes", 64'(nstrobe), 64'd6);
        chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
        chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
